com_frame_feeder: RTL and testbench
===================================

// Module: com_frame_feeder
// PURPOSE
//  Producer side of the centroid pixel interface: scans the video timing stream, emits (x,y,valid)
//  for every active pixel whose mask bit is set, and pulses tabulate once per frame after the last
//  active pixel. Then holds off new frames until center_of_mass returns its result (or a timeout).
//  Sits between the threshold/mask stage and center_of_mass in the visualizer pipeline.
// PARAMETERS
//  H_ACTIVE        1024  active pixels per line; last pixel at hcount_in == H_ACTIVE-1
//  V_ACTIVE        768   active lines per frame; last line at vcount_in == V_ACTIVE-1
//  TIMEOUT_CYCLES  1024  max cycles in WAIT_RESULT before abandoning the result
// PORTS
//  clk_in             in   1   system clock
//  rst_in             in   1   asynchronous, active-high reset
//  hcount_in          in   11  pixel column of current sample
//  vcount_in          in   10  pixel row of current sample
//  active_in          in   1   sample lies in active video region
//  mask_in            in   1   sample belongs to tracked object
//  com_valid_in       in   1   center_of_mass result strobe (its valid_out)
//  x_out              out  11  column of emitted pixel
//  y_out              out  10  row of emitted pixel
//  valid_out          out  1   x_out/y_out carry a masked pixel this cycle
//  tabulate_out       out  1   one-cycle end-of-frame strobe
//  pixel_count_out    out  20  masked pixels streamed in the last tabulated frame
//  frames_skipped_out out  8   frame starts seen while waiting, saturating at 255
//  timeout_out        out  1   one-cycle pulse when WAIT_RESULT expires
// BEHAVIOUR
//  - Reset (any time, async): all outputs 0, state IDLE, internal counters 0.
//  - frame_start = active_in && hcount_in==0 && vcount_in==0.
//    frame_end   = active_in && hcount_in==H_ACTIVE-1 && vcount_in==V_ACTIVE-1.
//  - States:
//    IDLE -> STREAM on frame_start. Never enters STREAM mid-frame.
//    STREAM -> TABULATE on frame_end.
//    TABULATE -> WAIT_RESULT if frame count > 0; else -> IDLE. center_of_mass gives no result
//      for zero pixels, so the block must not wait in that case.
//    WAIT_RESULT -> IDLE on com_valid_in, or when the timer reaches TIMEOUT_CYCLES-1.
//  - Pixel path: in STREAM, or on the frame_start cycle in IDLE, any sample with
//    active_in && mask_in is registered. Next cycle: valid_out=1, x_out=hcount_in, y_out=vcount_in.
//    Latency is exactly 1 cycle. When valid_out=0, x_out/y_out hold their last values.
//  - The frame_end sample itself is streamed: its valid_out occurs in the TABULATE-entry cycle.
//    tabulate_out=1 on the following cycle, so valid_out and tabulate_out are never high together.
//  - valid_out is forced 0 in TABULATE, WAIT_RESULT and IDLE (except the frame_start pixel).
//  - Frame pixel counter: 20 bits; cleared on frame_start; incremented per emitted pixel.
//    It is copied to pixel_count_out in the cycle tabulate_out is high.
//  - WAIT_RESULT timer: cleared on entry. On expiry: timeout_out=1 for 1 cycle, go to IDLE.
//    If com_valid_in arrives in the expiry cycle, the result wins: no timeout_out.
//  - frame_start seen in TABULATE or WAIT_RESULT increments frames_skipped_out, saturating at 255.
//    Cleared only by reset.
//  - If com_valid_in and frame_start occur in the same cycle, that frame is skipped.
//    The next transition is WAIT_RESULT -> IDLE.
//  - com_valid_in outside WAIT_RESULT is ignored.
// STRUCTURE
//  - Shared package com_pkg holds: typedef enum feeder_state_t {IDLE, STREAM, TABULATE, WAIT_RESULT};
//    H_ACTIVE/V_ACTIVE defaults; widths X_W=11, Y_W=10.
//  - One sub-module: com_wait_timer (load/enable/expire pulse, parameter TIMEOUT_CYCLES).
//    Everything else is in a single always_ff FSM plus the registered pixel path.
// TESTING
//  1. Reset, then a frame with mask at (5,3), (1023,767) -> valid_out at (5,3) and (1023,767),
//     1 cycle after each sample. tabulate_out 1 cycle after the last valid. pixel_count_out=2.
//  2. Frame with no mask bits -> tabulate_out pulses once, pixel_count_out=0.
//     Returns to IDLE with no timeout; the next frame streams normally.
//  3. Full-mask frame (786432 pixels) -> pixel_count_out=786432 with no wrap.
//     Bench center_of_mass returns (511,383).
//  4. com_valid_in withheld -> timeout_out pulses TIMEOUT_CYCLES cycles after WAIT_RESULT entry.
//     Two frame starts during the wait -> frames_skipped_out=2.
//  5. Assert rst_in mid-STREAM at (100,50) -> outputs 0 that same cycle. Nothing is emitted until
//     the next frame_start. A mid-frame mask pixel after reset release produces no valid_out.
//  6. com_valid_in in the same cycle as timer expiry -> IDLE, no timeout_out.
//     A stray com_valid_in while in STREAM -> no state change.

Source files
------------

// File: rtl/com_pkg.sv
// Shared types and constants for the centroid pixel feeder.
// Holds the feeder state encoding, default frame geometry and the coordinate/counter widths
// used by com_frame_feeder and its wait timer.
package com_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        TABULATE,
        WAIT_RESULT
    } feeder_state_t;

    localparam int H_ACTIVE_DEFAULT = 1024;
    localparam int V_ACTIVE_DEFAULT = 768;
    localparam int TIMEOUT_DEFAULT  = 1024;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int CNT_W  = 20;
    localparam int SKIP_W = 8;

endpackage

// File: rtl/com_wait_timer.sv
// Result wait timer: counts enabled cycles after a load and flags the last allowed cycle.
// Latency: expire is combinational, high while enabled on count == TIMEOUT_CYCLES-1.
// Ports: clk/rst (async, active-high), load (clear count), enable (count), expire (last cycle).
module com_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expire = enable && (count == LAST);

    // The count parks on LAST once expired; the owner leaves the wait state that cycle anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/com_frame_feeder.sv
// Producer side of the centroid interface: streams masked active pixels, strobes tabulate once
// per frame, then holds off new frames until center_of_mass answers or the wait times out.
// Latency: x/y/valid 1 cycle after the sample; tabulate 2 cycles after the frame_end sample.
// Ports: clk_in/rst_in (async, active-high); hcount_in/vcount_in/active_in/mask_in video samples;
//        com_valid_in result strobe; x_out/y_out/valid_out pixel stream; tabulate_out and
//        pixel_count_out per frame; frames_skipped_out (saturating); timeout_out pulse.
module com_frame_feeder
    import com_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [X_W-1:0]    hcount_in,
    input  logic [Y_W-1:0]    vcount_in,
    input  logic              active_in,
    input  logic              mask_in,
    input  logic              com_valid_in,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              valid_out,
    output logic              tabulate_out,
    output logic [CNT_W-1:0]  pixel_count_out,
    output logic [SKIP_W-1:0] frames_skipped_out,
    output logic              timeout_out
);

    localparam logic [X_W-1:0] H_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_ACTIVE - 1);

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic             frame_start;
    logic             frame_end;
    logic             accepting;
    logic             emit;
    logic             busy;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expire;
    logic [CNT_W-1:0] frame_count;

    assign frame_start = active_in && (hcount_in == '0) && (vcount_in == '0);
    assign frame_end   = active_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

    // The frame_start pixel is taken while still in IDLE so the first pixel is never lost.
    assign accepting = (state == STREAM) || ((state == IDLE) && frame_start);
    assign emit      = accepting && active_in && mask_in;

    // Frames that begin while the previous result is outstanding are dropped and counted.
    assign busy = (state == TABULATE) || (state == WAIT_RESULT);

    assign timer_load = (state == TABULATE);
    assign timer_en   = (state == WAIT_RESULT);

    com_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk   (clk_in),
        .rst   (rst_in),
        .load  (timer_load),
        .enable(timer_en),
        .expire(timer_expire)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (frame_start) state_next = STREAM;
            STREAM:      if (frame_end) state_next = TABULATE;
            // center_of_mass never answers an empty frame, so do not wait for it.
            TABULATE:    state_next = (frame_count != '0) ? WAIT_RESULT : IDLE;
            WAIT_RESULT: if (com_valid_in || timer_expire) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_out              <= '0;
            y_out              <= '0;
            valid_out          <= 1'b0;
            tabulate_out       <= 1'b0;
            pixel_count_out    <= '0;
            frames_skipped_out <= '0;
            timeout_out        <= 1'b0;
            frame_count        <= '0;
        end else begin
            valid_out <= emit;
            if (emit) begin
                x_out <= hcount_in;
                y_out <= vcount_in;
            end

            // A masked frame_start pixel is itself the first count of the new frame.
            if (frame_start && !busy) begin
                frame_count <= CNT_W'(emit);
            end else if (emit) begin
                frame_count <= frame_count + 1'b1;
            end

            // TABULATE is entered on the frame_end sample, so the count already includes it.
            tabulate_out <= (state == TABULATE);
            if (state == TABULATE) begin
                pixel_count_out <= frame_count;
            end

            // A result arriving on the expiry cycle takes precedence over the timeout.
            timeout_out <= (state == WAIT_RESULT) && timer_expire && !com_valid_in;

            if (frame_start && busy && (frames_skipped_out != '1)) begin
                frames_skipped_out <= frames_skipped_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_com_frame_feeder.sv
module tb_com_frame_feeder;

    localparam int H = 16;
    localparam int V = 8;
    localparam int T = 32;
    localparam int LINE = H + 2;
    localparam int LAST_IDX = V * LINE - 1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        active_in = 1'b0;
    logic        mask_in = 1'b0;
    logic        com_valid_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic [19:0] pixel_count_out;
    logic [7:0]  frames_skipped_out;
    logic        timeout_out;

    com_frame_feeder #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .active_in(active_in),
        .mask_in(mask_in),
        .com_valid_in(com_valid_in),
        .x_out(x_out),
        .y_out(y_out),
        .valid_out(valid_out),
        .tabulate_out(tabulate_out),
        .pixel_count_out(pixel_count_out),
        .frames_skipped_out(frames_skipped_out),
        .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] c;
    } pix_t;

    pix_t exp_pix[$];
    pix_t obs_pix[$];
    int   obs_tab_cyc[$];
    int   obs_tab_cnt[$];
    int   obs_to_cyc[$];
    int   overlap = 0;
    int   total = 0;
    int   bad = 0;
    int   last_cyc = 0;
    bit   mask_bits [V][H];

    // Output recorder; expectations are formed by the scenario tasks.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (valid_out) obs_pix.push_back('{16'(x_out), 16'(y_out), 32'(cyc)});
            if (tabulate_out) begin
                obs_tab_cyc.push_back(cyc);
                obs_tab_cnt.push_back(int'(pixel_count_out));
            end
            if (timeout_out) obs_to_cyc.push_back(cyc);
            if (valid_out && tabulate_out) overlap++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int sidx(input int h, input int v);
        return v * LINE + h;
    endfunction

    function automatic int mask_total();
        int n = 0;
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H; h++)
                n += int'(mask_bits[v][h]);
        return n;
    endfunction

    task automatic fill_mask(input int mode);
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H; h++)
                mask_bits[v][h] = (mode == 1) ? 1'b1 :
                                  (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic clear_obs();
        exp_pix.delete();
        obs_pix.delete();
        obs_tab_cyc.delete();
        obs_tab_cnt.delete();
        obs_to_cyc.delete();
        overlap = 0;
    endtask

    task automatic drive(input bit act, input int h, input int v, input bit m, input bit cv);
        @(posedge clk_in);
        #1;
        active_in    = act;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        mask_in      = m;
        com_valid_in = cv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Raster scan with two blanking samples per line; accepted masked samples are expected
    // back on valid_out exactly one cycle later, in raster order.
    task automatic drive_frame(input bit accept, input int cv_idx, input int first_idx,
                               input int last_idx);
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < LINE; h++) begin
                int idx;
                bit act;
                bit m;
                idx = sidx(h, v);
                act = (h < H);
                m = 1'b0;
                if (act) m = mask_bits[v][h];
                if (idx >= first_idx && idx <= last_idx) begin
                    drive(act, h, v, m, idx == cv_idx);
                    if (accept && m) exp_pix.push_back('{16'(h), 16'(v), 32'(cyc + 1)});
                    if (act && h == H - 1 && v == V - 1) last_cyc = cyc;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_in = 1'b1;
        idle(3);
        rst_in = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle(3);
        total++;
        if ({x_out, y_out, valid_out, tabulate_out, pixel_count_out, frames_skipped_out,
             timeout_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got x=%0d y=%0d v=%b t=%b cnt=%0d skip=%0d to=%b want all 0",
                     x_out, y_out, valid_out, tabulate_out, pixel_count_out,
                     frames_skipped_out, timeout_out);
        end
        rst_in = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        apply_reset();
        clear_obs();
        fill_mask(0);
        mask_bits[3][5] = 1'b1;
        mask_bits[V-1][H-1] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != exp_pix.size()) begin
            bad++;
            $display("FAIL basic_npix got=%0d want=%0d", obs_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            total++;
            if (obs_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL basic_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]);
            end
        end
        total++;
        if (obs_tab_cyc.size() != 1 || obs_tab_cyc[0] != last_cyc + 2) begin
            bad++;
            $display("FAIL basic_tab_cycle got n=%0d want one at %0d", obs_tab_cyc.size(),
                     last_cyc + 2);
        end
        total++;
        if (obs_tab_cnt.size() != 1 || obs_tab_cnt[0] != 2) begin
            bad++;
            $display("FAIL basic_count got n=%0d want count 2", obs_tab_cnt.size());
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL basic_overlap got=%0d want=0", overlap);
        end
        total++;
        if (x_out !== 11'(H - 1) || y_out !== 10'(V - 1) || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold got x=%0d y=%0d v=%b want x=%0d y=%0d v=0",
                     x_out, y_out, valid_out, H - 1, V - 1);
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(T + 4);
        total++;
        if (obs_to_cyc.size() != 0) begin
            bad++;
            $display("FAIL basic_no_timeout got=%0d want=0", obs_to_cyc.size());
        end
    endtask

    task automatic test_empty();
        clear_obs();
        fill_mask(0);
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(T + 4);
        total++;
        if (obs_tab_cnt.size() != 1 || obs_tab_cnt[0] != 0 || obs_pix.size() != 0) begin
            bad++;
            $display("FAIL empty_tab got ntab=%0d npix=%0d want ntab=1 count=0 npix=0",
                     obs_tab_cnt.size(), obs_pix.size());
        end
        total++;
        if (obs_to_cyc.size() != 0) begin
            bad++;
            $display("FAIL empty_no_timeout got=%0d want=0", obs_to_cyc.size());
        end
        clear_obs();
        fill_mask(2);
        mask_bits[1][1] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != exp_pix.size()) begin
            bad++;
            $display("FAIL empty_next_npix got=%0d want=%0d", obs_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            total++;
            if (obs_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL empty_next_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]);
            end
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_full();
        clear_obs();
        fill_mask(1);
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_tab_cnt.size() != 1 || obs_tab_cnt[0] != H * V) begin
            bad++;
            $display("FAIL full_count got n=%0d want count %0d", obs_tab_cnt.size(), H * V);
        end
        total++;
        if (obs_pix.size() != H * V) begin
            bad++;
            $display("FAIL full_npix got=%0d want=%0d", obs_pix.size(), H * V);
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            total++;
            if (obs_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL full_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]);
            end
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_timeout_skip();
        int tc;
        apply_reset();
        clear_obs();
        fill_mask(2);
        mask_bits[0][0] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        tc = last_cyc + 2;
        idle(2);
        drive(1'b1, 0, 0, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 0, 0, 1'b1, 1'b0);
        idle(T + 4);
        total++;
        if (obs_to_cyc.size() != 1 || obs_to_cyc[0] != tc + T) begin
            bad++;
            $display("FAIL timeout_cycle got n=%0d first=%0d want one at %0d", obs_to_cyc.size(),
                     (obs_to_cyc.size() > 0) ? obs_to_cyc[0] : -1, tc + T);
        end
        total++;
        if (frames_skipped_out !== 8'd2) begin
            bad++;
            $display("FAIL timeout_skipped got=%0d want=2", frames_skipped_out);
        end
        total++;
        if (obs_pix.size() != mask_total()) begin
            bad++;
            $display("FAIL timeout_npix got=%0d want=%0d", obs_pix.size(), mask_total());
        end
    endtask

    task automatic test_reset_mid();
        int ridx;
        apply_reset();
        clear_obs();
        fill_mask(2);
        mask_bits[3][4] = 1'b1;
        mask_bits[5][9] = 1'b0;
        mask_bits[6][3] = 1'b1;
        ridx = sidx(10, 5);
        drive_frame(1'b1, -1, 0, ridx - 1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        active_in = 1'b1;
        hcount_in = 11'd10;
        vcount_in = 10'd5;
        mask_in = 1'b1;
        #1;
        total++;
        if ({x_out, y_out, valid_out, tabulate_out, pixel_count_out, timeout_out} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got x=%0d y=%0d v=%b t=%b cnt=%0d want all 0",
                     x_out, y_out, valid_out, tabulate_out, pixel_count_out);
        end
        rst_in = 1'b0;
        drive_frame(1'b0, -1, ridx + 1, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != exp_pix.size() || obs_tab_cyc.size() != 0) begin
            bad++;
            $display("FAIL midreset_quiet got npix=%0d ntab=%0d want npix=%0d ntab=0",
                     obs_pix.size(), obs_tab_cyc.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            total++;
            if (obs_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL midreset_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]);
            end
        end
        clear_obs();
        fill_mask(2);
        mask_bits[2][7] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != mask_total() || obs_tab_cnt.size() != 1 ||
            obs_tab_cnt[0] != mask_total()) begin
            bad++;
            $display("FAIL midreset_next got npix=%0d ntab=%0d want %0d pixels, one tabulate",
                     obs_pix.size(), obs_tab_cnt.size(), mask_total());
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_race_and_stray();
        apply_reset();
        clear_obs();
        fill_mask(2);
        mask_bits[2][2] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        // Result lands on the last cycle the wait allows (T-1 cycles after tabulate).
        idle(T - 2);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(T + 4);
        total++;
        if (obs_to_cyc.size() != 0) begin
            bad++;
            $display("FAIL race_timeout got=%0d want=0", obs_to_cyc.size());
        end
        clear_obs();
        fill_mask(2);
        mask_bits[4][3] = 1'b1;
        drive_frame(1'b1, sidx(7, 4), 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != exp_pix.size() || obs_tab_cnt.size() != 1 ||
            obs_tab_cnt[0] != mask_total()) begin
            bad++;
            $display("FAIL stray_frame got npix=%0d ntab=%0d want npix=%0d count=%0d",
                     obs_pix.size(), obs_tab_cnt.size(), exp_pix.size(), mask_total());
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_same_cycle();
        apply_reset();
        clear_obs();
        fill_mask(0);
        mask_bits[1][2] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(2);
        clear_obs();
        fill_mask(1);
        drive_frame(1'b0, 0, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != 0 || obs_tab_cyc.size() != 0 || frames_skipped_out !== 8'd1) begin
            bad++;
            $display("FAIL samecycle_skip got npix=%0d ntab=%0d skip=%0d want 0 0 1",
                     obs_pix.size(), obs_tab_cyc.size(), frames_skipped_out);
        end
        clear_obs();
        fill_mask(2);
        mask_bits[5][5] = 1'b1;
        drive_frame(1'b1, -1, 0, LAST_IDX);
        idle(3);
        total++;
        if (obs_pix.size() != mask_total() || obs_tab_cnt.size() != 1 ||
            obs_tab_cnt[0] != mask_total()) begin
            bad++;
            $display("FAIL samecycle_next got npix=%0d ntab=%0d want %0d pixels",
                     obs_pix.size(), obs_tab_cnt.size(), mask_total());
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            fill_mask(2);
            drive_frame(1'b1, -1, 0, LAST_IDX);
            idle(3);
            total++;
            if (obs_pix.size() != exp_pix.size()) begin
                bad++;
                $display("FAIL rand%0d_npix got=%0d want=%0d", f, obs_pix.size(), exp_pix.size());
            end
            foreach (exp_pix[i]) if (i < obs_pix.size()) begin
                total++;
                if (obs_pix[i] !== exp_pix[i]) begin
                    bad++;
                    $display("FAIL rand%0d_pix[%0d] got=%h want=%h", f, i, obs_pix[i], exp_pix[i]);
                end
            end
            total++;
            if (obs_tab_cnt.size() != 1 || obs_tab_cnt[0] != mask_total() ||
                obs_tab_cyc[0] != last_cyc + 2 || overlap != 0) begin
                bad++;
                $display("FAIL rand%0d_tab got ntab=%0d overlap=%0d want count %0d at %0d",
                         f, obs_tab_cnt.size(), overlap, mask_total(), last_cyc + 2);
            end
            idle($urandom_range(0, 15));
            drive(1'b0, 0, 0, 1'b0, 1'b1);
            idle(2);
            total++;
            if (obs_to_cyc.size() != 0) begin
                bad++;
                $display("FAIL rand%0d_timeout got=%0d want=0", f, obs_to_cyc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_timeout_skip();
        test_reset_mid();
        test_race_and_stray();
        test_same_cycle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
